// File: rtl/zion_processor_component_lib_inst_fetch.sv
// Instruction fetch: issues in-order memory requests from the current PC, queues responses with their PCs for decode.
// Queue adds one cycle after the memory response; requests are credit-limited so responses are never back-pressured.

module zion_processor_component_lib_inst_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_dat_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = ptr_inc(wptr_q);
            if (pop_i)  rptr_d = ptr_inc(rptr_q);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !clr_i) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rptr_q];
    assign count_o   = count_q;
endmodule

module zion_processor_component_lib_inst_fetch #(
    parameter int PC_WIDTH        = 32,
    parameter int INST_WIDTH      = 32,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   iPc,
    output logic                  oStall,
    input  logic                  iFlush,
    output logic                  oReqVld,
    output logic [PC_WIDTH-1:0]   oReqAddr,
    input  logic                  iReqRdy,
    input  logic                  iRspVld,
    input  logic [INST_WIDTH-1:0] iRspInst,
    output logic                  oInstVld,
    output logic [PC_WIDTH-1:0]   oInstPc,
    output logic [INST_WIDTH-1:0] oInst,
    input  logic                  iInstRdy
);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int QW = $clog2(QUEUE_DEPTH+1);
    localparam int SW = ((OW > QW) ? OW : QW) + 1;

    logic [OW-1:0]       out_cnt_q, out_cnt_d;
    logic [OW-1:0]       drop_cnt_q, drop_cnt_d;
    logic [OW-1:0]       pend_count;
    logic [QW-1:0]       q_count;
    logic [PC_WIDTH-1:0] pend_pc;
    logic                can_issue;
    logic                req_fire;
    logic                rsp_keep;
    logic                inst_pop;

    // Reserve a queue slot for every request in flight so responses always fit.
    assign can_issue = (out_cnt_q < OW'(MAX_OUTSTANDING)) &&
                       ((SW'(out_cnt_q) + SW'(q_count)) < SW'(QUEUE_DEPTH));

    assign oReqVld  = can_issue & ~iFlush & ~rst;
    assign oReqAddr = iPc;
    assign req_fire = oReqVld & iReqRdy;
    assign oStall   = ~(req_fire | iFlush);

    assign rsp_keep = iRspVld & (drop_cnt_q == '0) & ~iFlush;
    assign oInstVld = (q_count != '0) & ~iFlush & ~rst;
    assign inst_pop = oInstVld & iInstRdy;

    always_comb begin
        out_cnt_d  = out_cnt_q + OW'(req_fire) - OW'(iRspVld);
        drop_cnt_d = drop_cnt_q;
        // Everything still in flight after a redirect is wrong-path.
        if (iFlush) begin
            drop_cnt_d = out_cnt_q - OW'(iRspVld);
        end else if (iRspVld && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    zion_processor_component_lib_inst_fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .push_i     (req_fire),
        .push_dat_i (iPc),
        .pop_i      (iRspVld),
        .pop_dat_o  (pend_pc),
        .count_o    (pend_count)
    );

    zion_processor_component_lib_inst_fetch_fifo #(
        .WIDTH (PC_WIDTH + INST_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_inst_queue (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (iFlush),
        .push_i     (rsp_keep),
        .push_dat_i ({pend_pc, iRspInst}),
        .pop_i      (inst_pop),
        .pop_dat_o  ({oInstPc, oInst}),
        .count_o    (q_count)
    );

    a_rsp_with_outstanding: assert property (@(posedge clk) disable iff (rst)
        iRspVld |-> (out_cnt_q != '0));
    a_out_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        out_cnt_q <= OW'(MAX_OUTSTANDING));
    a_drop_le_out: assert property (@(posedge clk) disable iff (rst)
        drop_cnt_q <= out_cnt_q);
    a_pend_tracks_out: assert property (@(posedge clk) disable iff (rst)
        pend_count == out_cnt_q);
endmodule
